// File: rtl/parking_lane_arbiter_if.sv
// Lane-side signal bundle for the car-park gate arbiter: request/sensor inputs
// and gate, grant and occupancy status outputs.
interface parking_lane_arbiter_if;
  logic       enter_req;
  logic       exit_req;
  logic       pass_sensor;
  logic       gate_open;
  logic       gate_sel;
  logic       enter_grant;
  logic       exit_grant;
  logic       enter_deny;
  logic       timeout_err;
  logic [3:0] occupied;
  logic [3:0] spots;
  logic       full;
  logic       empty;
  logic       busy;

  modport slave (
    input  enter_req, exit_req, pass_sensor,
    output gate_open, gate_sel, enter_grant, exit_grant, enter_deny,
           timeout_err, occupied, spots, full, empty, busy
  );

  modport master (
    output enter_req, exit_req, pass_sensor,
    input  gate_open, gate_sel, enter_grant, exit_grant, enter_deny,
           timeout_err, occupied, spots, full, empty, busy
  );
endinterface

// File: rtl/parking_lane_arbiter.sv
// Single-barrier arbiter shared by the entry and exit lanes: round-robin grant,
// open/pass/close sequencing and occupancy tracking once a car has fully passed.
module parking_lane_arbiter #(
  parameter int TOTAL_SPOTS  = 15,
  parameter int PASS_TIMEOUT = 32,
  parameter int CLOSE_CYCLES = 4
) (
  input  logic                   clk_in,
  input  logic                   reset,
  parking_lane_arbiter_if.slave  lane
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_OPEN      = 2'd1,
    S_WAIT_PASS = 2'd2,
    S_CLOSE     = 2'd3
  } state_e;

  // One timer serves both the pass timeout and the close hold.
  localparam int TMAX = (PASS_TIMEOUT > CLOSE_CYCLES) ? PASS_TIMEOUT : CLOSE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] PASS_LAST  = TW'(PASS_TIMEOUT - 1);
  localparam logic [TW-1:0] CLOSE_LAST = TW'(CLOSE_CYCLES - 1);
  localparam logic [3:0]    CAPACITY   = 4'(TOTAL_SPOTS);

  state_e        state_q, state_d;
  logic          last_sel_q, last_sel_d;
  logic          gate_sel_q, gate_sel_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    occupied_q, occupied_d;
  logic          enter_grant_q, enter_grant_d;
  logic          exit_grant_q, exit_grant_d;
  logic          timeout_err_q, timeout_err_d;

  logic full_s;
  logic empty_s;
  logic entry_ok_s;
  logic exit_ok_s;

  assign full_s     = (occupied_q == CAPACITY);
  assign empty_s    = (occupied_q == 4'd0);
  assign entry_ok_s = lane.enter_req && !full_s;
  assign exit_ok_s  = lane.exit_req && !empty_s;

  // Next-state, timer, occupancy and pulse computation.
  always_comb begin
    state_d       = state_q;
    last_sel_d    = last_sel_q;
    gate_sel_d    = gate_sel_q;
    timer_d       = timer_q;
    occupied_d    = occupied_q;
    enter_grant_d = 1'b0;
    exit_grant_d  = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // On a tie, last_sel_q == 1 (exit went last) hands the gate to entry.
        if (entry_ok_s && (!exit_ok_s || last_sel_q)) begin
          state_d       = S_OPEN;
          gate_sel_d    = 1'b0;
          last_sel_d    = 1'b0;
          timer_d       = '0;
          enter_grant_d = 1'b1;
        end else if (exit_ok_s) begin
          state_d      = S_OPEN;
          gate_sel_d   = 1'b1;
          last_sel_d   = 1'b1;
          timer_d      = '0;
          exit_grant_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OPEN: begin
        if (lane.pass_sensor) begin
          state_d = S_WAIT_PASS;
          timer_d = '0;
        end else if (timer_q == PASS_LAST) begin
          state_d       = S_CLOSE;
          timer_d       = '0;
          timeout_err_d = 1'b1;
        end else begin
          timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      S_WAIT_PASS: begin
        if (!lane.pass_sensor) begin
          state_d = S_CLOSE;
          timer_d = '0;
          if (!gate_sel_q && !full_s) begin
            occupied_d = occupied_q + 4'd1;
          end else if (gate_sel_q && !empty_s) begin
            occupied_d = occupied_q - 4'd1;
          end else begin
            occupied_d = occupied_q;
          end
        end else begin
          state_d = S_WAIT_PASS;
        end
      end
      S_CLOSE: begin
        if (timer_q == CLOSE_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q       <= S_IDLE;
      last_sel_q    <= 1'b1;
      gate_sel_q    <= 1'b0;
      timer_q       <= '0;
      occupied_q    <= 4'd0;
      enter_grant_q <= 1'b0;
      exit_grant_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_sel_q    <= last_sel_d;
      gate_sel_q    <= gate_sel_d;
      timer_q       <= timer_d;
      occupied_q    <= occupied_d;
      enter_grant_q <= enter_grant_d;
      exit_grant_q  <= exit_grant_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign lane.gate_open   = (state_q == S_OPEN) || (state_q == S_WAIT_PASS);
  assign lane.gate_sel    = gate_sel_q;
  assign lane.enter_grant = enter_grant_q;
  assign lane.exit_grant  = exit_grant_q;
  assign lane.enter_deny  = (state_q == S_IDLE) && lane.enter_req && full_s;
  assign lane.timeout_err = timeout_err_q;
  assign lane.occupied    = occupied_q;
  assign lane.spots       = CAPACITY - occupied_q;
  assign lane.full        = full_s;
  assign lane.empty       = empty_s;
  assign lane.busy        = (state_q != S_IDLE);

endmodule

// File: doc/parking_lane_arbiter.md
# parking_lane_arbiter

Single-gate lane arbiter for the car-park controller. Entry and exit lanes share one barrier and one occupancy counter. The block grants the barrier to one lane at a time, sequences the gate open/pass/close cycle, and updates occupancy only after a car has fully passed the sensor. It sits between the lane request sensors and the display logic that consumes `spots`, and runs on the divided system clock.

## Interface
- `TOTAL_SPOTS`, 15: capacity, 1..15.
- `PASS_TIMEOUT`, 32: maximum cycles in OPEN without the sensor going high.
- `CLOSE_CYCLES`, 4: cycles the gate holds closed before the next grant.

- `clk_in` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `enter_req` in 1: level; a car is waiting at the entry.
- `exit_req` in 1: level; a car is waiting at the exit.
- `pass_sensor` in 1: level; high while a car is under the barrier.
- `gate_open` out 1: barrier open command.
- `gate_sel` out 1: lane owning the gate; 0 = entry, 1 = exit.
- `enter_grant` out 1: one-cycle pulse when entry is granted.
- `exit_grant` out 1: one-cycle pulse when exit is granted.
- `enter_deny` out 1: high in IDLE while `enter_req` is high and the park is full.
- `timeout_err` out 1: one-cycle pulse when a grant expires without a pass.
- `occupied` out 4: cars inside.
- `spots` out 4: free spots, equal to `TOTAL_SPOTS - occupied`.
- `full` out 1: `occupied == TOTAL_SPOTS`.
- `empty` out 1: `occupied == 0`.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, OPEN, WAIT_PASS, CLOSE. All state is in registers on `clk_in`.
- Eligibility: entry is eligible when `enter_req && !full`. Exit is eligible when `exit_req && !empty`.
- IDLE, one lane eligible: grant that lane.
- IDLE, both lanes eligible: round-robin. Grant the lane opposite to `last_sel`; `last_sel` resets to exit, so entry wins the first tie.
- On a grant: latch `gate_sel`, update `last_sel`, clear the timer, go to OPEN.
- IDLE, nothing eligible: stay in IDLE. Requests are ignored outside IDLE, so requesters must hold their request until granted.
- OPEN:
  - `gate_open` = 1.
  - `pass_sensor` sampled 1 → WAIT_PASS.
  - Otherwise the timer increments. When the timer == `PASS_TIMEOUT-1` with `pass_sensor` still 0 → CLOSE, pulse `timeout_err`, leave occupancy unchanged.
- WAIT_PASS:
  - `gate_open` = 1; no timeout in this state.
  - `pass_sensor` sampled 0 → CLOSE.
  - On that transition, occupancy updates: +1 if `gate_sel` = 0, −1 if `gate_sel` = 1.
  - The update is guarded: no increment at `TOTAL_SPOTS`, no decrement at 0. Eligibility already prevents both cases.
- CLOSE: `gate_open` = 0. Count `CLOSE_CYCLES` cycles, then go to IDLE.
- `gate_sel` holds its value through CLOSE and into IDLE until the next grant.
- `spots`, `full`, `empty`, `busy` and `gate_open` are combinational decodes of registers. They are glitch-free relative to `clk_in`.
- Width rules: `occupied` is 4 bits unsigned; `spots` is computed at 4 bits and never underflows.
- Reset values:
  - state IDLE, `last_sel` = 1 (exit), timer 0, `occupied` = 0.
  - `gate_open` = 0, `gate_sel` = 0, all pulse outputs 0.
  - `spots` = `TOTAL_SPOTS`, `full` = 0, `empty` = 1, `busy` = 0.

## Timing
- Grant latency: a request that is eligible in an IDLE cycle at edge N causes state OPEN, `gate_open` = 1 and a one-cycle grant pulse after edge N.
- Pass detection: `pass_sensor` is sampled at the edge, with one cycle from a sensor rise to WAIT_PASS.
- Count update: `occupied`, `spots` and `full`/`empty` change on the same edge that enters CLOSE, i.e. one cycle after `pass_sensor` falls.
- Gate close: `gate_open` drops on that same edge.
- Timeout: OPEN lasts at most `PASS_TIMEOUT` cycles. `timeout_err` is high during the first CLOSE cycle.
- Minimum transaction length: 1 cycle in OPEN + 1 cycle in WAIT_PASS + `CLOSE_CYCLES`. The earliest next grant is on the edge after the last CLOSE cycle.
- Reset mid-operation: the next edge forces all reset values. The gate closes immediately, the in-flight car is not counted, and occupancy clears to 0.
- A `pass_sensor` pulse while in IDLE or CLOSE is ignored.

## Test plan
- **Entry pass:** after reset, `enter_req`=1; at cycle 3 `pass_sensor`=1, at cycle 6 `pass_sensor`=0 → `enter_grant` pulse in cycle 1; `gate_open` high for cycles 1–6; `occupied`=1 and `spots`=14 from cycle 7; IDLE again after 4 cycles of CLOSE.
- **Tie round-robin:** with `occupied`=5, assert `enter_req` and `exit_req` together and complete 3 transactions → grants go entry, exit, entry; final `occupied`=6.
- **Full park:** fill to 15 → `full`=1, `spots`=0. Then `enter_req`=1 alone gives `enter_deny`=1, `gate_open` stays 0. Then add `exit_req`=1 → exit is granted; after the pass `occupied`=14.
- **Timeout:** grant entry and never raise `pass_sensor` → `gate_open` high for exactly 32 cycles, `timeout_err` pulses once, `occupied` unchanged.
- **Empty exit:** at `occupied`=0, `exit_req`=1 → no grant, `busy`=0.
- **Reset mid-operation:** assert `reset` during WAIT_PASS with `occupied`=7 → next cycle `gate_open`=0, state IDLE, `occupied`=0, `spots`=15; the following tie grants entry first.
